// File: rtl/rpt_msg_arbiter_if.sv
// Report-channel bundle: requester message handshake plus the serialized
// log-stream handshake toward the trace sink.
interface rpt_msg_arbiter_if #(
  parameter int N  = 4,
  parameter int CW = 16,
  parameter int TW = 32
);
  localparam int SW = $clog2(N);

  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [2*N-1:0]  req_type;
  logic [2*N-1:0]  req_svrt;
  logic [2*N-1:0]  req_act;
  logic [CW*N-1:0] req_code;

  logic            out_vld;
  logic            out_rdy;
  logic [1:0]      out_type;
  logic [1:0]      out_svrt;
  logic [SW-1:0]   out_src;
  logic [CW-1:0]   out_code;
  logic [TW-1:0]   out_time;

  // Requesters and log sink side
  modport master (
    output req_vld, req_type, req_svrt, req_act, req_code, out_rdy,
    input  req_rdy, out_vld, out_type, out_svrt, out_src, out_code, out_time
  );

  // Arbiter side
  modport slave (
    input  req_vld, req_type, req_svrt, req_act, req_code, out_rdy,
    output req_rdy, out_vld, out_type, out_svrt, out_src, out_code, out_time
  );
endinterface

// File: rtl/rpt_msg_arbiter.sv
// Report message arbiter: severity filter, round-robin grant, FIFO with
// cycle timestamps and sticky STOP/EXIT flags toward a single log sink.
// Optional per-type pop counters are built when RPT_ARB_CNT_EN is defined.
module rpt_msg_arbiter #(
  parameter int N     = 4,
  parameter int CW    = 16,
  parameter int DEPTH = 8,
  parameter int TW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  rpt_msg_arbiter_if.slave   bus,
  input  logic [1:0]         cfg_svrt,
  input  logic               stop_clr,
  output logic               stop_o,
  output logic               exit_o,
  output logic [15:0]        drop_cnt
`ifdef RPT_ARB_CNT_EN
  ,
  output logic [15:0]        cnt_info,
  output logic [15:0]        cnt_warn,
  output logic [15:0]        cnt_err,
  output logic [15:0]        cnt_fatal
`endif
);
  localparam int SW = $clog2(N);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]    typ;
    logic [1:0]    svrt;
    logic [1:0]    act;
    logic [SW-1:0] src;
    logic [CW-1:0] code;
    logic [TW-1:0] tstamp;
  } entry_t;

  // Saturating 16-bit add used by every event counter
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] popcnt(input logic [N-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + 16'(v[i]);
    return c;
  endfunction

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_rr;
  logic [TW-1:0] r_time;

  logic [N-1:0]  w_pass, w_drop, w_cand, w_gnt;
  logic          w_full, w_nempty, w_grant_en, w_gnt_any, w_push, w_pop;
  logic [SW-1:0] w_gnt_idx;
  entry_t        w_head, w_new;

  // Severity filter: low-severity messages are acknowledged and discarded at once
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pass[i] = (bus.req_svrt[2*i +: 2] >= cfg_svrt);
      w_drop[i] = bus.req_vld[i] & ~w_pass[i];
      w_cand[i] = bus.req_vld[i] & w_pass[i];
    end
  end

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_nempty   = (r_count != '0);
  assign w_grant_en = ~w_full & ~stop_o & ~exit_o;

  // Round-robin search starting at the rotating pointer
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(r_rr) + k) % N;
      if (!w_gnt_any && w_grant_en && w_cand[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = SW'(idx);
      end
    end
    w_gnt = w_gnt_any ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
  end

  assign bus.req_rdy = w_drop | w_gnt;
  assign w_push      = w_gnt_any;
  assign w_pop       = w_nempty & bus.out_rdy;

  // Assemble the entry of the granted requester, stamped with the current cycle
  always_comb begin
    w_new.typ    = bus.req_type[2*w_gnt_idx +: 2];
    w_new.svrt   = bus.req_svrt[2*w_gnt_idx +: 2];
    w_new.act    = bus.req_act[2*w_gnt_idx +: 2];
    w_new.src    = w_gnt_idx;
    w_new.code   = bus.req_code[CW*w_gnt_idx +: CW];
    w_new.tstamp = r_time;
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign bus.out_vld  = w_nempty;
  assign bus.out_type = w_nempty ? w_head.typ    : '0;
  assign bus.out_svrt = w_nempty ? w_head.svrt   : '0;
  assign bus.out_src  = w_nempty ? w_head.src    : '0;
  assign bus.out_code = w_nempty ? w_head.code   : '0;
  assign bus.out_time = w_nempty ? w_head.tstamp : '0;

  // FIFO storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  // Control state: pointers, occupancy, arbitration pointer, timestamp, flags, drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr     <= '0;
      r_time   <= '0;
      stop_o   <= 1'b0;
      exit_o   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      r_time   <= r_time + TW'(1);
      drop_cnt <= sat_add16(drop_cnt, popcnt(w_drop));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr     <= (w_gnt_idx == SW'(N-1)) ? '0 : w_gnt_idx + SW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop && w_head.act == 2'd1) stop_o <= 1'b1;
      else if (stop_clr)               stop_o <= 1'b0;
      if (w_pop && w_head.act == 2'd2) exit_o <= 1'b1;
    end
  end

`ifdef RPT_ARB_CNT_EN
  // Per-type tally of messages delivered to the sink
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_info  <= '0;
      cnt_warn  <= '0;
      cnt_err   <= '0;
      cnt_fatal <= '0;
    end else if (w_pop) begin
      case (w_head.typ)
        2'd0:    cnt_info  <= sat_add16(cnt_info,  16'd1);
        2'd1:    cnt_warn  <= sat_add16(cnt_warn,  16'd1);
        2'd2:    cnt_err   <= sat_add16(cnt_err,   16'd1);
        default: cnt_fatal <= sat_add16(cnt_fatal, 16'd1);
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_rpt_msg_arbiter.sv
// Directed bench for rpt_msg_arbiter (N=4, CW=16, DEPTH=8, TW=32).
module tb_rpt_msg_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_svrt = 2'd0;
  logic        stop_clr = 1'b0;
  logic        stop_o, exit_o;
  logic [15:0] drop_cnt;
`ifdef RPT_ARB_CNT_EN
  logic [15:0] cnt_info, cnt_warn, cnt_err, cnt_fatal;
`endif

  int n_vec = 0;
  int n_err = 0;

  rpt_msg_arbiter_if #(.N(4), .CW(16), .TW(32)) bus ();

  rpt_msg_arbiter #(.N(4), .CW(16), .DEPTH(8), .TW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cfg_svrt (cfg_svrt),
    .stop_clr (stop_clr),
    .stop_o   (stop_o),
    .exit_o   (exit_o),
    .drop_cnt (drop_cnt)
`ifdef RPT_ARB_CNT_EN
    ,
    .cnt_info (cnt_info),
    .cnt_warn (cnt_warn),
    .cnt_err  (cnt_err),
    .cnt_fatal(cnt_fatal)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] t,
                         input logic [1:0] s, input logic [1:0] a, input logic [15:0] c);
    bus.req_vld[i]         = v;
    bus.req_type[2*i +: 2] = t;
    bus.req_svrt[2*i +: 2] = s;
    bus.req_act[2*i +: 2]  = a;
    bus.req_code[16*i +: 16] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_vld  = '0;
    bus.req_type = '0;
    bus.req_svrt = '0;
    bus.req_act  = '0;
    bus.req_code = '0;
    bus.out_rdy  = 1'b0;

    // Reset state
    do_reset();
    rst = 1'b1;
    mid();
    check_eq("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check_eq("rst_out_code", 32'(bus.out_code), 32'd0);
    check_eq("rst_stop", 32'(stop_o), 32'd0);
    check_eq("rst_exit", 32'(exit_o), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    rst = 1'b0;

    // Single message, timestamp captured on accept cycle (timestamp==2 there)
    step();
    step();
    set_req(0, 1'b1, 2'd0, 2'd0, 2'd0, 16'h1234);
    mid();
    check_eq("single_rdy", 32'(bus.req_rdy), 32'h1);
    check_eq("single_vld_pre", 32'(bus.out_vld), 32'd0);
    step();
    bus.req_vld = '0;
    mid();
    check_eq("single_vld", 32'(bus.out_vld), 32'd1);
    check_eq("single_src", 32'(bus.out_src), 32'd0);
    check_eq("single_code", 32'(bus.out_code), 32'h1234);
    check_eq("single_time", bus.out_time, 32'd2);
    step();
    bus.out_rdy = 1'b1;
    mid();
    check_eq("single_hold_time", bus.out_time, 32'd2);
    step();
    mid();
    check_eq("single_popped", 32'(bus.out_vld), 32'd0);

    // Round robin with all requesters active
    do_reset();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd1, 2'd1, 2'd0, 16'(16'hC0 + i));
    for (int j = 0; j < 6; j++) begin
      mid();
      check_eq("rr_grant", 32'(bus.req_rdy), 32'(1 << (j % 4)));
      if (j > 0) begin
        check_eq("rr_src", 32'(bus.out_src), 32'((j - 1) % 4));
        check_eq("rr_code", 32'(bus.out_code), 32'(16'hC0 + (j - 1) % 4));
      end
      step();
    end
    bus.req_vld = '0;

    // Severity filter and drop counter saturation
    do_reset();
    bus.out_rdy = 1'b0;
    cfg_svrt = 2'd2;
    set_req(1, 1'b1, 2'd1, 2'd1, 2'd0, 16'h0011);
    set_req(2, 1'b1, 2'd2, 2'd2, 2'd0, 16'h0022);
    mid();
    check_eq("flt_rdy", 32'(bus.req_rdy), 32'h6);
    step();
    bus.req_vld = '0;
    mid();
    check_eq("flt_drop1", 32'(drop_cnt), 32'd1);
    check_eq("flt_vld", 32'(bus.out_vld), 32'd1);
    check_eq("flt_src", 32'(bus.out_src), 32'd2);
    step();
    cfg_svrt = 2'd3;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0);
    mid();
    check_eq("flt_all_rdy", 32'(bus.req_rdy), 32'hF);
    repeat (16383) step();
    mid();
    check_eq("flt_drop_65533", 32'(drop_cnt), 32'd65533);
    step();
    mid();
    check_eq("flt_drop_sat", 32'(drop_cnt), 32'hFFFF);
    repeat (1200) step();
    mid();
    check_eq("flt_drop_hold", 32'(drop_cnt), 32'hFFFF);
    check_eq("flt_head_kept", 32'(bus.out_code), 32'h0022);
    step();
    bus.req_vld = '0;
    cfg_svrt = 2'd0;

    // FIFO full: 8 accepted, 9th held off, no push-through on pop
    do_reset();
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 2'd0, 2'd0, 2'd0, 16'(16'h100 + k));
      mid();
      check_eq("full_acc_rdy", 32'(bus.req_rdy), 32'h1);
      step();
    end
    set_req(0, 1'b1, 2'd0, 2'd0, 2'd0, 16'h108);
    mid();
    check_eq("full_9th_rdy", 32'(bus.req_rdy), 32'h0);
    check_eq("full_head", 32'(bus.out_code), 32'h100);
    step();
    mid();
    check_eq("full_head_stable", 32'(bus.out_code), 32'h100);
    step();
    bus.out_rdy = 1'b1;
    mid();
    check_eq("full_no_pushthru", 32'(bus.req_rdy), 32'h0);
    step();
    bus.out_rdy = 1'b0;
    mid();
    check_eq("full_after_pop_rdy", 32'(bus.req_rdy), 32'h1);
    check_eq("full_next_head", 32'(bus.out_code), 32'h101);
    step();
    bus.req_vld = '0;
    bus.out_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      mid();
      check_eq("full_drain", 32'(bus.out_code), 32'(16'h100 + k));
      step();
    end
    mid();
    check_eq("full_empty", 32'(bus.out_vld), 32'd0);
    step();

    // STOP action and stop_clr
    do_reset();
    bus.out_rdy = 1'b1;
    set_req(0, 1'b1, 2'd2, 2'd0, 2'd1, 16'h000A);
    mid();
    check_eq("stop_push_rdy", 32'(bus.req_rdy), 32'h1);
    step();
    bus.req_vld = '0;
    set_req(1, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0011);
    mid();
    check_eq("stop_head", 32'(bus.out_code), 32'h000A);
    check_eq("stop_pre_rdy", 32'(bus.req_rdy), 32'h2);
    step();
    mid();
    check_eq("stop_set", 32'(stop_o), 32'd1);
    check_eq("stop_inhibit", 32'(bus.req_rdy), 32'h0);
    check_eq("stop_drain_src", 32'(bus.out_src), 32'd1);
    step();
    mid();
    check_eq("stop_drained", 32'(bus.out_vld), 32'd0);
    check_eq("stop_still_inh", 32'(bus.req_rdy), 32'h0);
    step();
    stop_clr = 1'b1;
    mid();
    check_eq("stop_clr_cycle_rdy", 32'(bus.req_rdy), 32'h0);
    step();
    stop_clr = 1'b0;
    mid();
    check_eq("stop_cleared", 32'(stop_o), 32'd0);
    check_eq("stop_resume_rdy", 32'(bus.req_rdy), 32'h2);
    step();
    bus.req_vld = '0;
    set_req(0, 1'b1, 2'd0, 2'd0, 2'd1, 16'h000B);
    mid();
    check_eq("stop2_push_rdy", 32'(bus.req_rdy), 32'h1);
    step();
    bus.req_vld = '0;
    stop_clr = 1'b1;
    mid();
    check_eq("stop2_head", 32'(bus.out_code), 32'h000B);
    step();
    stop_clr = 1'b0;
    mid();
    check_eq("stop_set_wins", 32'(stop_o), 32'd1);
    step();

    // EXIT action, then reset mid-drain
    do_reset();
    bus.out_rdy = 1'b0;
    set_req(0, 1'b1, 2'd3, 2'd3, 2'd2, 16'h00E0);
    mid();
    check_eq("exit_push_rdy", 32'(bus.req_rdy), 32'h1);
    step();
    bus.req_vld = '0;
    for (int k = 1; k <= 3; k++) begin
      set_req(1, 1'b1, 2'd0, 2'd1, 2'd0, 16'(16'hB0 + k));
      mid();
      check_eq("exit_fill_rdy", 32'(bus.req_rdy), 32'h2);
      step();
    end
    bus.req_vld = '0;
    bus.out_rdy = 1'b1;
    mid();
    check_eq("exit_head", 32'(bus.out_code), 32'h00E0);
    check_eq("exit_pre", 32'(exit_o), 32'd0);
    step();
    bus.out_rdy = 1'b0;
    cfg_svrt = 2'd1;
    set_req(1, 1'b1, 2'd0, 2'd1, 2'd0, 16'h00B4);
    set_req(3, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0033);
    mid();
    check_eq("exit_set", 32'(exit_o), 32'd1);
    check_eq("exit_only_drop_rdy", 32'(bus.req_rdy), 32'h8);
    check_eq("exit_drain_head", 32'(bus.out_code), 32'h00B1);
    step();
    bus.req_vld = '0;
    mid();
    check_eq("exit_drop", 32'(drop_cnt), 32'd1);
    check_eq("exit_queued", 32'(bus.out_vld), 32'd1);
    step();
    rst = 1'b1;
    step();
    mid();
    check_eq("exit_rst_exit", 32'(exit_o), 32'd0);
    check_eq("exit_rst_vld", 32'(bus.out_vld), 32'd0);
    check_eq("exit_rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("exit_rst_code", 32'(bus.out_code), 32'd0);
    step();
    rst = 1'b0;
    cfg_svrt = 2'd0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
